// File: rtl/delay_timer_if.sv
// Handshake bundle between the display init sequencer (master) and delay_timer (slave).
// The abort signal exists only when DELAY_TIMER_ABORT_EN is defined.
interface delay_timer_if #(
  parameter int DLY_BITS = 16
);
  logic                start;
  logic [DLY_BITS-1:0] delay_in;
  logic                busy;
  logic                done;
  logic                por_done;
  logic [DLY_BITS-1:0] remaining;
`ifdef DELAY_TIMER_ABORT_EN
  logic                abort;

  modport master (output start, delay_in, abort, input busy, done, por_done, remaining);
  modport slave  (input start, delay_in, abort, output busy, done, por_done, remaining);
`else
  modport master (output start, delay_in, input busy, done, por_done, remaining);
  modport slave  (input start, delay_in, output busy, done, por_done, remaining);
`endif
endinterface

// File: rtl/delay_timer.sv
// Prescaled down-counter delay timer: automatic power-on wait, then start/busy/done delays.
// Optional feature macro: DELAY_TIMER_ABORT_EN (adds abort of a running delay).
//
// state   | meaning
// ST_POR  | power-on wait of POR_TICKS ticks after reset, por_done low
// ST_IDLE | ready, prescaler held at 0, start accepted
// ST_RUN  | requested delay counting down, busy high
module delay_timer #(
  parameter int TICK_DIV  = 16000,
  parameter int DLY_BITS  = 16,
  parameter int POR_TICKS = 10
) (
  input  logic          clk,
  input  logic          rst,
  delay_timer_if.slave  bus
);

  localparam int PRE_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state;
  logic [PRE_BITS-1:0] pre_cnt;
  logic [DLY_BITS-1:0] rem_r;
  logic                busy_r;
  logic                done_r;
  logic                por_done_r;
  logic                tick;

  assign tick = (pre_cnt == PRE_BITS'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_POR;
      pre_cnt    <= '0;
      rem_r      <= DLY_BITS'(POR_TICKS);
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      por_done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_POR: begin
          if (rem_r == '0) begin
            // zero-length power-on wait completes on the first active edge
            state      <= ST_IDLE;
            pre_cnt    <= '0;
            por_done_r <= 1'b1;
          end else if (tick) begin
            pre_cnt <= '0;
            rem_r   <= rem_r - DLY_BITS'(1);
            if (rem_r == DLY_BITS'(1)) begin
              state      <= ST_IDLE;
              por_done_r <= 1'b1;
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_BITS'(1);
          end
        end

        ST_IDLE: begin
          pre_cnt <= '0;
          if (bus.start && por_done_r) begin
            rem_r <= bus.delay_in;
            if (bus.delay_in == '0) begin
              done_r <= 1'b1;
            end else begin
              busy_r <= 1'b1;
              state  <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
`ifdef DELAY_TIMER_ABORT_EN
          if (bus.abort) begin
            state   <= ST_IDLE;
            busy_r  <= 1'b0;
            rem_r   <= '0;
            pre_cnt <= '0;
          end else
`endif
          if (tick) begin
            pre_cnt <= '0;
            if (rem_r <= DLY_BITS'(1)) begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              rem_r  <= '0;
            end else begin
              rem_r <= rem_r - DLY_BITS'(1);
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_BITS'(1);
          end
        end

        default: begin
          state   <= ST_POR;
          pre_cnt <= '0;
          rem_r   <= DLY_BITS'(POR_TICKS);
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.por_done  = por_done_r;
  assign bus.remaining = rem_r;

endmodule

// File: tb/tb_delay_timer.sv
// Self-checking bench for delay_timer with TICK_DIV=4, DLY_BITS=8, POR_TICKS=3.
// Define DELAY_TIMER_ABORT_EN at build time to also exercise abort.
module tb_delay_timer;

  localparam int TICK_DIV  = 4;
  localparam int DLY_BITS  = 8;
  localparam int POR_TICKS = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  delay_timer_if #(.DLY_BITS(DLY_BITS)) bus ();

  delay_timer #(
    .TICK_DIV (TICK_DIV),
    .DLY_BITS (DLY_BITS),
    .POR_TICKS(POR_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = edge index relative to the accept edge (k=0); masks record done/busy seen after each edge
  typedef struct {
    logic [7:0]  d0;
    int          hold_until;
    int          pulse_at;
    logic [7:0]  pulse_d;
    int          ncyc;
    logic [63:0] exp_dmask;
    logic [63:0] exp_bmask;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic por_check(input string tag);
    for (int k = 1; k <= TICK_DIV * POR_TICKS; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_por_done"}, 64'(bus.por_done), 64'(k == TICK_DIV * POR_TICKS));
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
      check({tag, "_remaining"}, 64'(bus.remaining), 64'(POR_TICKS - k / TICK_DIV));
    end
  endtask

  task automatic run_seq(input vec_t v, output logic [63:0] dmask, output logic [63:0] bmask,
                         output logic [7:0] rem0, output logic [7:0] rem_end);
    dmask = '0;
    bmask = '0;
    for (int k = 0; k <= v.ncyc; k++) begin
      bus.start    = (k <= v.hold_until) || (k == v.pulse_at);
      bus.delay_in = (k == v.pulse_at) ? v.pulse_d : v.d0;
      @(posedge clk);
      @(negedge clk);
      dmask[k] = bus.done;
      bmask[k] = bus.busy;
      if (k == 0) rem0 = bus.remaining;
    end
    bus.start    = 1'b0;
    bus.delay_in = '0;
    rem_end      = bus.remaining;
  endtask

  initial begin
    logic [63:0] dm;
    logic [63:0] bm;
    logic [7:0]  r0;
    logic [7:0]  re;
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.delay_in = '0;
`ifdef DELAY_TIMER_ABORT_EN
    bus.abort    = 1'b0;
`endif

    vecs[0] = '{8'd5, 0, -1, 8'd0, 24, 64'h0010_0000, 64'h000F_FFFF};
    vecs[1] = '{8'd0, 0, -1, 8'd0,  4, 64'h1,         64'h0};
    vecs[2] = '{8'd1, 0, -1, 8'd0,  6, 64'h10,        64'hF};
    vecs[3] = '{8'd2, 0,  3, 8'd9, 12, 64'h100,       64'hFF};
    vecs[4] = '{8'd2, 9, -1, 8'd0, 20, 64'h2_0100,    64'h1_FEFF};
    vecs[5] = '{8'd3, 0, -1, 8'd0, 14, 64'h1000,      64'hFFF};
    vecs[6] = '{8'd0, 1, -1, 8'd0,  4, 64'h3,         64'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_por_done", 64'(bus.por_done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_remaining", 64'(bus.remaining), 64'd3);

    rst = 1'b1;
    por_check("por1");

    for (int i = 0; i < 7; i++) begin
      run_seq(vecs[i], dm, bm, r0, re);
      check($sformatf("vec%0d_done_mask", i), dm, vecs[i].exp_dmask);
      check($sformatf("vec%0d_busy_mask", i), bm, vecs[i].exp_bmask);
      check($sformatf("vec%0d_rem_accept", i), 64'(r0), 64'(vecs[i].d0));
      check($sformatf("vec%0d_rem_end", i), 64'(re), 64'd0);
    end

    // reset in the middle of a running delay
    bus.start    = 1'b1;
    bus.delay_in = 8'd5;
    for (int k = 0; k <= 7; k++) begin
      if (k == 7) rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (k < 7) check($sformatf("midrst_busy_k%0d", k), 64'(bus.busy), 64'd1);
    end
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_por_done", 64'(bus.por_done), 64'd0);
    check("midrst_remaining", 64'(bus.remaining), 64'd3);
    rst = 1'b1;
    por_check("por2");

    // start while POR is running is ignored
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.delay_in = 8'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("por_start_busy", 64'(bus.busy), 64'd0);
    check("por_start_remaining", 64'(bus.remaining), 64'd3);
    repeat (TICK_DIV * POR_TICKS - 1) @(posedge clk);
    @(negedge clk);
    check("por3_por_done", 64'(bus.por_done), 64'd1);
    check("por3_busy", 64'(bus.busy), 64'd0);

`ifdef DELAY_TIMER_ABORT_EN
    // abort sampled on the expiry edge wins: no done pulse
    bus.start    = 1'b1;
    bus.delay_in = 8'd5;
    dm = '0;
    for (int k = 0; k <= 24; k++) begin
      bus.abort = (k == 20);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      dm[k] = bus.done;
      if (k == 20) begin
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_remaining", 64'(bus.remaining), 64'd0);
      end
    end
    bus.abort = 1'b0;
    check("abort_done_mask", dm, 64'd0);

    // abort together with start in IDLE: start accepted
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    bus.delay_in = 8'd1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_idle_busy", 64'(bus.busy), 64'd1);
    check("abort_idle_remaining", 64'(bus.remaining), 64'd1);
    repeat (TICK_DIV) @(posedge clk);
    @(negedge clk);
    check("abort_idle_done", 64'(bus.done), 64'd1);
    check("abort_idle_busy_end", 64'(bus.busy), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
